// File: rtl/instr_sequencer_if.sv
// Sequencer bus: instruction FIFO write side, CPU handshake and result report.
// master drives stimulus/CPU inputs, slave is the sequencer.
interface instr_sequencer_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          wr_en;
   logic [15:0]   wr_data;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          run;
   logic          cpu_waiting;
   logic [15:0]   cpu_out;
   logic          cpu_N;
   logic          cpu_V;
   logic          cpu_Z;
   logic [15:0]   cpu_instr;
   logic          cpu_load;
   logic          cpu_start;
   logic [15:0]   result;
   logic [2:0]    result_flags;
   logic          result_valid;
   logic [7:0]    retired;
   logic          busy;
   logic          timeout_err;

   modport master (
      output wr_en, wr_data, run, cpu_waiting, cpu_out,
      output cpu_N, cpu_V, cpu_Z,
      input  full, empty, count, cpu_instr, cpu_load, cpu_start,
      input  result, result_flags, result_valid, retired, busy,
      input  timeout_err
   );

   modport slave (
      input  wr_en, wr_data, run, cpu_waiting, cpu_out,
      input  cpu_N, cpu_V, cpu_Z,
      output full, empty, count, cpu_instr, cpu_load, cpu_start,
      output result, result_flags, result_valid, retired, busy,
      output timeout_err
   );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: FIFO of 16-bit words issued one at a time to a CPU
// through a load/start/ack/exec handshake, with timeout and result capture.
module instr_sequencer #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 32
) (
   input logic              clk,
   input logic              rst,
   instr_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, START, ACK, EXEC, DONE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] fcnt;
   logic [TW-1:0] wcnt;
   logic [15:0]   instr_q;
   logic [15:0]   res_q;
   logic [2:0]    flg_q;
   logic          rv_q;
   logic [7:0]    ret_q;
   logic          err_q;
   logic          push;
   logic          pop;
   logic          tmo;
   logic          set_err;

   // A pop in LOAD frees a slot, so a push into a full FIFO still lands.
   assign pop  = (state == LOAD);
   assign push = bus.wr_en && (!bus.full || pop);
   assign tmo  = (wcnt >= TW'(TIMEOUT - 1));

   assign bus.full         = (fcnt == CW'(DEPTH));
   assign bus.empty        = (fcnt == '0);
   assign bus.count        = fcnt;
   assign bus.cpu_instr    = pop ? mem[rptr] : instr_q;
   assign bus.cpu_load     = pop;
   assign bus.cpu_start    = (state == START);
   assign bus.result       = res_q;
   assign bus.result_flags = flg_q;
   assign bus.result_valid = rv_q;
   assign bus.retired      = ret_q;
   assign bus.busy         = (state != IDLE);
   assign bus.timeout_err  = err_q;

   always_comb begin
      state_nx = state;
      set_err  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.run && !bus.empty && bus.cpu_waiting && !err_q)
               state_nx = LOAD;
         end
         LOAD:  state_nx = START;
         START: state_nx = ACK;
         ACK: begin
            if (!bus.cpu_waiting) begin
               state_nx = EXEC;
            end else if (tmo) begin
               state_nx = IDLE;
               set_err  = 1'b1;
            end
         end
         EXEC: begin
            if (bus.cpu_waiting) begin
               state_nx = DONE;
            end else if (tmo) begin
               state_nx = IDLE;
               set_err  = 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst && push) mem[wptr] <= bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         fcnt    <= '0;
         wcnt    <= '0;
         instr_q <= '0;
         res_q   <= '0;
         flg_q   <= '0;
         rv_q    <= 1'b0;
         ret_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         rv_q <= (state == DONE);
         if (push) wptr <= wptr + 1'b1;
         if (pop) begin
            rptr    <= rptr + 1'b1;
            instr_q <= mem[rptr];
         end
         if (push && !pop)      fcnt <= fcnt + 1'b1;
         else if (pop && !push) fcnt <= fcnt - 1'b1;
         // Counts cycles spent waiting on the CPU after the start strobe.
         if (state == START)
            wcnt <= '0;
         else if (state == ACK || state == EXEC)
            wcnt <= wcnt + 1'b1;
         if (set_err) err_q <= 1'b1;
         if (state == DONE) begin
            res_q <= bus.cpu_out;
            flg_q <= {bus.cpu_Z, bus.cpu_N, bus.cpu_V};
            ret_q <= ret_q + 1'b1;
         end
      end
   end
endmodule
